// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame length and scan-code constants.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;

  typedef logic [7:0] scan_code_t;

  localparam scan_code_t SCAN_BREAK = 8'hF0;
  localparam scan_code_t SCAN_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_keyboard_if.sv
// Consumer-side bus of the keyboard receiver: head-of-queue scan code, pop handshake and overflow flag.
interface ps2_keyboard_if;
  import ps2_pkg::*;

  scan_code_t data;
  logic       ready;
  logic       nextdata_n;
  logic       overflow;

  modport master (output data, output ready, output overflow, input nextdata_n);
  modport slave  (input data, input ready, input overflow, output nextdata_n);

endinterface

// File: rtl/ps2_fifo.sv
// Small circular scan-code queue; one slot is kept free so full and empty stay distinguishable.
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic       pop,
  input  scan_code_t wdata,
  output scan_code_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  scan_code_t       mem [DEPTH];
  logic [PTR_W-1:0] w_ptr;
  logic [PTR_W-1:0] r_ptr;

  assign full  = (PTR_W'(w_ptr + 1'b1) == r_ptr);
  assign empty = (w_ptr == r_ptr);
  assign rdata = mem[r_ptr];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[w_ptr] <= wdata;
        w_ptr      <= w_ptr + 1'b1;
      end
      if (pop && !empty) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: oversamples the raw lines, deframes 11-bit frames and queues
// good scan codes for a downstream consumer.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_keyboard_if.master bus
);

  logic [SYNC_STAGES-1:0]    clk_sync;
  logic [1:0]                data_sync;
  logic [3:0]                count;
  logic [PS2_FRAME_BITS-2:0] shift;
  logic                      sample;
  logic                      data_bit;
  logic                      last_bit;
  logic                      frame_ok;
  logic                      push;
  logic                      pop;
  logic                      full;
  logic                      empty;

  // Falling edge seen on the two oldest stages; data uses two flops so it lines up with them.
  assign sample   = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign data_bit = data_sync[1];
  assign last_bit = (count == 4'(PS2_FRAME_BITS - 1));

  assign frame_ok = ~shift[0] & data_bit & (^shift[PS2_FRAME_BITS-2:1]);
  assign push     = sample & last_bit & frame_ok;
  assign pop      = ~bus.nextdata_n;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Stop bit is never stored: it is judged straight off the sampler in the same cycle.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      count <= '0;
    end else if (sample) begin
      if (last_bit) begin
        count <= '0;
      end else begin
        shift[count] <= data_bit;
        count        <= count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      bus.overflow <= 1'b0;
    end else if (push && full) begin
      bus.overflow <= 1'b1;
    end else if (pop && !empty) begin
      bus.overflow <= 1'b0;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .pop   (pop),
    .wdata (shift[PS2_FRAME_BITS-3:1]),
    .rdata (bus.data),
    .full  (full),
    .empty (empty)
  );

  assign bus.ready = ~empty;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed plus randomized bench for ps2_keyboard, checked against a queue-based model of the scan-code stream.
module tb_ps2_keyboard;
  import ps2_pkg::*;

  localparam int HALF     = 20;
  localparam int CAPACITY = 7;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  scan_code_t model_q[$];
  logic       model_ovf = 1'b0;

  ps2_keyboard_if kb_if ();

  ps2_keyboard #(
    .FIFO_DEPTH  (8),
    .SYNC_STAGES (3)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (kb_if.master)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".ready"}, {7'd0, kb_if.ready}, {7'd0, model_q.size() != 0});
    checkOutput({tag, ".overflow"}, {7'd0, kb_if.overflow}, {7'd0, model_ovf});
    if (model_q.size() != 0)
      checkOutput({tag, ".data"}, kb_if.data, model_q[0]);
  endtask

  // Device drives data while the clock is high, then pulls the clock low.
  task automatic applyStimulus(input scan_code_t b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    logic        par;
    par  = ~(^b) ^ bad_par;
    bits = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    if (nbits == 11 && !bad_par) begin
      if (model_q.size() < CAPACITY) model_q.push_back(b);
      else model_ovf = 1'b1;
    end
  endtask

  task automatic popN(input int n);
    @(negedge clk);
    kb_if.nextdata_n = 1'b0;
    repeat (n) @(negedge clk);
    kb_if.nextdata_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (model_q.size() != 0) begin
        void'(model_q.pop_front());
        model_ovf = 1'b0;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  initial begin
    scan_code_t ovf_codes [8] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};
    scan_code_t b;
    bit         bad;

    kb_if.nextdata_n = 1'b1;
    doReset();
    checkAll("reset");

    applyStimulus(8'h1C, 1'b0, 11);
    checkAll("first_1c");

    popN(1);
    applyStimulus(8'h15, 1'b0, 11);
    applyStimulus(SCAN_BREAK, 1'b0, 11);
    applyStimulus(8'h15, 1'b0, 11);
    checkAll("makebreak_0");
    popN(1);
    checkAll("makebreak_1");
    popN(1);
    checkAll("makebreak_2");
    popN(1);
    checkAll("makebreak_empty");

    applyStimulus(8'h1C, 1'b1, 11);
    checkAll("bad_parity");
    applyStimulus(8'h1D, 1'b0, 11);
    checkAll("resync_1d");
    popN(1);

    foreach (ovf_codes[i]) applyStimulus(ovf_codes[i], 1'b0, 11);
    checkAll("overflow_full");
    popN(1);
    checkAll("overflow_cleared");
    popN(6);
    checkAll("overflow_drained");

    applyStimulus(SCAN_EXT, 1'b0, 11);
    applyStimulus(8'h75, 1'b0, 11);
    applyStimulus(8'h6B, 1'b0, 11);
    checkAll("level_queued");
    popN(3);
    checkAll("level_pop3");
    popN(1);
    checkAll("level_pop_empty");

    applyStimulus(8'h77, 1'b0, 5);
    doReset();
    checkAll("midframe_reset");
    applyStimulus(8'h43, 1'b0, 11);
    checkAll("after_reset_43");
    popN(1);
    checkAll("after_reset_single");

    for (int k = 0; k < 14; k++) begin
      b   = scan_code_t'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      applyStimulus(b, bad, 11);
      checkAll("random_rx");
      if ($urandom_range(0, 2) == 0) begin
        popN($urandom_range(1, 3));
        checkAll("random_pop");
      end
    end
    popN(8);
    checkAll("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- PS/2 device-to-host receiver for keyboard scan codes.
- Oversamples the raw ps2_clk/ps2_data lines on the system clock.
- Deframes 11-bit frames, checks start, parity and stop bits, and pushes valid bytes into a small FIFO.
- Downstream logic (key decoders, tone generators) pops scan codes through a ready/nextdata_n handshake.

Parameters:
- FIFO_DEPTH, 8, number of FIFO slots (power of 2); usable capacity is FIFO_DEPTH-1.
- SYNC_STAGES, 3, flops in the ps2_clk synchronizer/edge-detect chain (minimum 3).

Ports:
- clk  in  1  system clock (e.g. 50 MHz); all logic on its rising edge.
- clrn  in  1  synchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock line (asynchronous).
- ps2_data  in  1  raw PS/2 data line (asynchronous).
- data  out  8  scan code at the FIFO head; valid while ready=1.
- ready  out  1  FIFO not empty.
- nextdata_n  in  1  active-low pop request.
- overflow  out  1  sticky flag: a frame was dropped because the FIFO was full.

Behaviour:
- Reset (clk edge with clrn=0): bit counter=0, write/read pointers=0, overflow=0, synchronizer chain=all 1s. Result: ready=0, data=FIFO[0] (contents don't care).
- Sync and edge detect:
  - ps2_clk is shifted through SYNC_STAGES flops; ps2_data through 2 flops.
  - Sample event = the oldest two clk stages show 1 then 0 (falling edge).
  - The aligned synchronized data bit is captured on each sample event.
- Deframing:
  - A 4-bit counter 0..10 stores sampled bits into shift[count], LSB-first.
  - Bit 0 = start, bits 1-8 = data[0..7], bit 9 = odd parity, bit 10 = stop.
  - On the sample that stores bit 10, the counter returns to 0 and the frame is evaluated in that same cycle, using the just-sampled stop bit.
- Frame validity: start==0, stop==1, and XOR of data bits and parity ==1.
- Invalid frame: silently discarded; no flag; counter still restarts at 0.
- No inter-frame timeout; resynchronisation happens only via clrn.
- Push:
  - A valid frame with FIFO not full writes the byte at w_ptr; w_ptr increments (mod FIFO_DEPTH).
  - ready rises on the clk edge after the stop-bit sample event.
- Full is defined as (w_ptr+1)==r_ptr. A valid frame arriving when full is dropped and overflow is set to 1; FIFO contents are unchanged.
- Pop:
  - On every clk edge with ready=1 and nextdata_n=0, r_ptr increments and overflow clears to 0.
  - Level-sensitive: one entry per clk cycle while held low.
  - nextdata_n=0 with FIFO empty has no effect.
- Simultaneous push and pop in one cycle: both take effect. Full is evaluated on pre-pop pointers, so a push while full is still dropped and overflow ends at 1.
- Outputs:
  - data = FIFO[r_ptr], combinational from registered pointers and storage.
  - ready = (w_ptr != r_ptr).
  - overflow is registered.
- Scan-code semantics (break prefix F0, extended E0) are passed through untouched; interpretation belongs downstream.

Decomposition:
- Shared package (ps2_pkg):
  - PS2_FRAME_BITS=11
  - SCAN_BREAK=8'hF0
  - SCAN_EXT=8'hE0
  - byte typedef for scan codes
- The clock divider (div_n) is a separate block and is not part of this module.
- One natural sub-module: ps2_fifo (DEPTH, 8-bit, push/pop/full/empty). The deframer stays in ps2_keyboard.

Test Plan:
- Reset: hold clrn=0 for 2 cycles -> ready=0, overflow=0.
  - Release and send 0x1C (data bits LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1) at ~12 kHz -> ready=1 the clk after the 11th falling edge, data=8'h1C.
- Make/break sequence: send 0x15, 0xF0, 0x15.
  - Pop each with a 1-cycle nextdata_n=0 pulse -> data reads 15, F0, 15 in order.
  - ready drops after the third pop.
- Bad parity: send 0x1C with parity bit 1 -> ready stays 0.
  - Then send 0x1D with correct parity (1) -> data=8'h1D; the stream has resynchronised.
- Overflow: send 8 valid frames without popping.
  - First 7 stored, overflow=1 after the 8th.
  - One pop clears overflow; data reads the first code.
- Level pop: with 3 entries queued, hold nextdata_n=0 for 3 clk cycles -> all 3 popped, ready=0.
  - A 4th cycle low leaves pointers unchanged.
- Reset mid-frame: assert clrn after 5 bits of a frame, then send a full 0x43 frame -> exactly one entry, 8'h43.
